// File: rtl/mdu_hilo_if.sv
// Execute-stage <-> multiply/divide unit bundle: request operands in, status and HI/LO out.
// Pure wiring, no latency; the unit stalls the requester through busy rather than a ready.
// No backpressure beyond busy: a start seen while busy is dropped.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers (divider built only with MDU_DIV_EN).
// Latency: MULT/DIV take WIDTH busy cycles then a one-cycle done; MTHI/MTLO land in one cycle.
// Backpressure: busy stalls the pipeline; start outside IDLE is ignored, never queued.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_hilo_if.slave  bus
);
    localparam int               CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MDU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;       // {partial product, multiplier} or {remainder, quotient}
    logic               res_neg;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Operand magnitudes at acceptance; op[0] clear means a signed operation.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        a_neg = ~bus.op[0] & bus.a[WIDTH-1];
        b_neg = ~bus.op[0] & bus.b[WIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
    end

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        mul_res  = res_neg ? -mul_next : mul_next;
    end

`ifdef MDU_DIV_EN
    logic               rem_neg;
    logic               div0;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic [WIDTH-1:0]   div_lo;
    logic [WIDTH-1:0]   div_hi;

    always_comb begin
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
        div_q     = div_next[WIDTH-1:0];
        div_r     = div_next[2*WIDTH-1:WIDTH];
        // A zero divisor shifts the whole dividend magnitude into the remainder,
        // so re-applying the dividend sign restores a unchanged in hi.
        div_lo    = div0 ? {WIDTH{1'b1}} : (res_neg ? -div_q : div_q);
        div_hi    = rem_neg ? -div_r : div_r;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            opnd    <= '0;
            acc     <= '0;
            res_neg <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MDU_DIV_EN
            rem_neg <= 1'b0;
            div0    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                state   <= S_MUL;
                                busy_q  <= 1'b1;
                                cnt     <= '0;
                                opnd    <= a_mag;
                                acc     <= {{WIDTH{1'b0}}, b_mag};
                                res_neg <= a_neg ^ b_neg;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
                                state   <= S_DIV;
                                busy_q  <= 1'b1;
                                cnt     <= '0;
                                opnd    <= b_mag;
                                acc     <= {{WIDTH{1'b0}}, a_mag};
                                res_neg <= a_neg ^ b_neg;
                                rem_neg <= a_neg;
                                div0    <= (bus.b == '0);
`else
                                state   <= S_DONE;
                                done_q  <= 1'b1;
`endif
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        hi_q   <= mul_res[2*WIDTH-1:WIDTH];
                        lo_q   <= mul_res[WIDTH-1:0];
                    end
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        hi_q   <= div_hi;
                        lo_q   <= div_lo;
                    end
                end
`endif
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed vectors push expected HI/LO and done cycle into a queue,
// an independent monitor pops and compares on every done pulse.
module tb_mdu_hilo;
    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

`ifdef MDU_DIV_EN
    localparam int DIV_LAT = W + 1;
`else
    localparam int DIV_LAT = 1;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    mdu_hilo_if #(.WIDTH(W)) bus ();

    mdu_hilo #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("hi", bus.hi, mon_e.hi);
                chk("lo", bus.lo, mon_e.lo);
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input bit poke);
        int t0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        t0        = cyc;
        exp_q.push_back('{eh, el, t0 + lat});
        @(negedge clk);
        // Scramble operands after acceptance; the unit must have latched them.
        bus.start = 1'b0;
        bus.op    = OP_MTHI;
        bus.a     = $urandom;
        bus.b     = $urandom;
        chk("busy_cycle1", 32'(bus.busy), (lat > 1) ? 32'd1 : 32'd0);
        #1;
        for (int i = 0; i < lat + 4; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            if (lat > 1 && cyc == t0 + W) chk("busy_cycleW", 32'(bus.busy), 32'd1);
            if (poke && cyc == t0 + 5) begin
                bus.start = 1'b1;
                bus.op    = OP_MTHI;
                bus.a     = 32'hDEADBEEF;
            end
            if (poke && cyc == t0 + 6) bus.start = 1'b0;
            #1;
        end
        chk("completion_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        cur_hi = eh;
        cur_lo = el;
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        chk("mt_hi", bus.hi, eh);
        chk("mt_lo", bus.lo, el);
        chk("mt_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("mt_busy_next", 32'(bus.busy), 32'd0);
        cur_hi = eh;
        cur_lo = el;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int t0;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        cur_hi = '0;
        cur_lo = '0;

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, W + 1, 1'b0);
        run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, W + 1, 1'b0);
        run_op(OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, W + 1, 1'b0);
        run_op(OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, W + 1, 1'b0);
        run_op(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, W + 1, 1'b1);

        run_mt(OP_MTHI, 32'h00001234, 32'h00001234, cur_lo);
        run_mt(OP_MTLO, 32'hCAFEF00D, cur_hi, 32'hCAFEF00D);
        run_mt(OP_RSVD, 32'h00000BAD, cur_hi, cur_lo);

`ifdef MDU_DIV_EN
        run_op(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, 1'b0);
        run_op(OP_DIVU, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, DIV_LAT, 1'b0);
        run_op(OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT, 1'b0);
        run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT, 1'b0);
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DIV_LAT, 1'b0);
        run_op(OP_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, DIV_LAT, 1'b0);
`else
        run_op(OP_DIV,  32'hFFFFFFF9, 32'h00000002, cur_hi, cur_lo, DIV_LAT, 1'b0);
        run_op(OP_DIVU, 32'h00000064, 32'h00000000, cur_hi, cur_lo, DIV_LAT, 1'b0);
`endif

        // Reset ten cycles into a long operation: everything clears at once, no done follows.
        @(negedge clk);
        bus.start = 1'b1;
`ifdef MDU_DIV_EN
        bus.op    = OP_DIV;
`else
        bus.op    = OP_MULT;
`endif
        bus.a     = 32'h00001000;
        bus.b     = 32'h00000003;
        t0        = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_hi", bus.hi, 32'd0);
        chk("rst_mid_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_hi", bus.hi, 32'd0);
        chk("post_rst_lo", bus.lo, 32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        cur_hi = '0;
        cur_lo = '0;

        run_op(OP_MULTU, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, W + 1, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
